// File: rtl/csci_or_pkg.sv
// Shared constants and elaboration-time helpers for the OR-reduction pipeline.
package csci_or_pkg;

  localparam int OR_DEFAULT_WIDTH = 16;

  // Floor log2. Widths are powers of two, so this is exact.
  function automatic int or_log2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 1; v = v >> 1) r++;
    return r;
  endfunction

  // Bit offset of tree level 'level' inside a bus that concatenates all levels,
  // widest first: WIDTH, WIDTH/2, ..., 1.
  function automatic int or_lvl_off(input int width, input int level);
    return 2 * width - 2 * (width >> level);
  endfunction

endpackage

// File: rtl/student_or_stage.sv
// One registered level of the OR tree: halves the word width and carries valid/last.
// With OR_REDUCE_IDX_EN defined, each node also carries the lowest set-bit index.
module student_or
(
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

module student_or_stage #(
  parameter int IN_W  = 2,
  parameter int IDX_W = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      up_valid_i,
  output logic                      up_ready_o,
  input  logic [IN_W-1:0]           up_data_i,
  input  logic                      up_last_i,
`ifdef OR_REDUCE_IDX_EN
  input  logic [IN_W*IDX_W-1:0]     up_idx_i,
  output logic [(IN_W/2)*IDX_W-1:0] dn_idx_o,
`endif
  output logic                      dn_valid_o,
  input  logic                      dn_ready_i,
  output logic [IN_W/2-1:0]         dn_data_o,
  output logic                      dn_last_o
);
  localparam int OUT_W = IN_W / 2;

  logic [OUT_W-1:0] or_w, data_q, data_d;
  logic             valid_q, valid_d, last_q, last_d;

  // A full register may still load when its downstream consumer takes the old word.
  assign up_ready_o = !valid_q || dn_ready_i;

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pair
    student_or u_or (
      .a_i (up_data_i[2*gi]),
      .b_i (up_data_i[2*gi+1]),
      .y_o (or_w[gi])
    );
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (up_ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = or_w;
        last_d = up_last_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_last_o  = last_q;

`ifdef OR_REDUCE_IDX_EN
  logic [OUT_W*IDX_W-1:0] idx_w, idx_q, idx_d;

  // Indices are absolute, so the lower node wins whenever it has any bit set.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_idx
    assign idx_w[gi*IDX_W +: IDX_W] = up_data_i[2*gi] ? up_idx_i[(2*gi)*IDX_W +: IDX_W]
                                                      : up_idx_i[(2*gi+1)*IDX_W +: IDX_W];
  end

  always_comb begin
    idx_d = idx_q;
    if (up_ready_o && up_valid_i) idx_d = idx_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign dn_idx_o = idx_q;
`endif

endmodule

// File: rtl/student_or_reduce_pipe.sv
// Pipelined OR-reduction tree with per-frame accumulation of the reduced result.
// Define OR_REDUCE_IDX_EN to add out_idx, the lowest set-bit index of each word.
module student_or_reduce_pipe
  import csci_or_pkg::*;
#(
  parameter int WIDTH = OR_DEFAULT_WIDTH,
  localparam int LEVELS = or_log2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_any,
  output logic              out_last
`ifdef OR_REDUCE_IDX_EN
  ,
  output logic [LEVELS-1:0] out_idx
`endif
);
  localparam int BUS_W = 2 * WIDTH - 1;

  logic [LEVELS:0]  lvl_valid, lvl_ready, lvl_last;
  logic [BUS_W-1:0] data_bus;
  logic             acc_q, acc_d, tree_any;

  assign lvl_valid[0]      = in_valid;
  assign lvl_last[0]       = in_last;
  assign data_bus[WIDTH-1:0] = in_data;
  assign in_ready          = lvl_ready[0];
  assign lvl_ready[LEVELS] = out_ready;

`ifdef OR_REDUCE_IDX_EN
  logic [LEVELS*BUS_W-1:0] idx_bus;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_idx_seed
    assign idx_bus[gi*LEVELS +: LEVELS] = LEVELS'(gi);
  end
`endif

  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int IN_W    = WIDTH >> gi;
    localparam int IN_OFF  = or_lvl_off(WIDTH, gi);
    localparam int OUT_OFF = or_lvl_off(WIDTH, gi + 1);

    student_or_stage #(
      .IN_W  (IN_W),
      .IDX_W (LEVELS)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid_i (lvl_valid[gi]),
      .up_ready_o (lvl_ready[gi]),
      .up_data_i  (data_bus[IN_OFF +: IN_W]),
      .up_last_i  (lvl_last[gi]),
`ifdef OR_REDUCE_IDX_EN
      .up_idx_i   (idx_bus[LEVELS*IN_OFF +: LEVELS*IN_W]),
      .dn_idx_o   (idx_bus[LEVELS*OUT_OFF +: LEVELS*(IN_W/2)]),
`endif
      .dn_valid_o (lvl_valid[gi+1]),
      .dn_ready_i (lvl_ready[gi+1]),
      .dn_data_o  (data_bus[OUT_OFF +: IN_W/2]),
      .dn_last_o  (lvl_last[gi+1])
    );
  end

  assign tree_any  = data_bus[BUS_W-1];
  assign out_valid = lvl_valid[LEVELS];
  assign out_any   = out_valid & (tree_any | acc_q);
  assign out_last  = out_valid & lvl_last[LEVELS];

`ifdef OR_REDUCE_IDX_EN
  // The surviving index points at the highest bit when nothing is set; mask it.
  assign out_idx = (out_valid && tree_any) ? idx_bus[LEVELS*(BUS_W-1) +: LEVELS] : '0;
`endif

  always_comb begin
    acc_d = acc_q;
    if (out_valid && out_ready) acc_d = out_last ? 1'b0 : out_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_d;
  end

endmodule

// File: tb/tb_student_or_reduce_pipe.sv
// Directed self-checking bench for student_or_reduce_pipe at WIDTH=16 (latency 4).
module tb_student_or_reduce_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic        out_any;
  logic        out_last;
`ifdef OR_REDUCE_IDX_EN
  logic [3:0]  out_idx;
`endif

  int checks;
  int failures;
  int nacc;
  logic took;

  logic [15:0] w      [5];
  logic        w_last [5];
  logic        e_any  [5];
  logic        e_last [5];

  student_or_reduce_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_any   (out_any),
    .out_last  (out_last)
`ifdef OR_REDUCE_IDX_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    w[0] = 16'h0001; w_last[0] = 1'b0; e_any[0] = 1'b1; e_last[0] = 1'b0;
    w[1] = 16'h0000; w_last[1] = 1'b1; e_any[1] = 1'b1; e_last[1] = 1'b1;
    w[2] = 16'h0000; w_last[2] = 1'b0; e_any[2] = 1'b0; e_last[2] = 1'b0;
    w[3] = 16'h0200; w_last[3] = 1'b1; e_any[3] = 1'b1; e_last[3] = 1'b1;
    w[4] = 16'h0000; w_last[4] = 1'b1; e_any[4] = 1'b0; e_last[4] = 1'b1;

    // Reset state
    tick(); tick();
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_out_any",   out_any,   1'b0);
    chk_bit("rst_out_last",  out_last,  1'b0);
    rst_n = 1'b1;
    #1;
    chk_bit("post_rst_in_ready", in_ready, 1'b1);

    // Single all-zero word frame, latency 4
    drive(1'b1, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    tick(); tick();
    chk_bit("zero_not_early", out_valid, 1'b0);
    tick();
    chk_bit("zero_valid", out_valid, 1'b1);
    chk_bit("zero_any",   out_any,   1'b0);
    chk_bit("zero_last",  out_last,  1'b1);
    tick();
    chk_bit("zero_drained", out_valid, 1'b0);

    // Back-to-back single-word frames, no bubble
    drive(1'b1, 16'h8000, 1'b1);
    chk_bit("b2b_in_ready0", in_ready, 1'b1);
    tick();
    drive(1'b1, 16'h0001, 1'b1);
    chk_bit("b2b_in_ready1", in_ready, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    tick(); tick();
    chk_bit("b2b_valid0", out_valid, 1'b1);
    chk_bit("b2b_any0",   out_any,   1'b1);
    chk_bit("b2b_last0",  out_last,  1'b1);
    tick();
    chk_bit("b2b_valid1", out_valid, 1'b1);
    chk_bit("b2b_any1",   out_any,   1'b1);
    tick();
    chk_bit("b2b_drained", out_valid, 1'b0);

    // Multi-word frame accumulation, then a fresh frame
    drive(1'b1, 16'h0000, 1'b0); tick();
    drive(1'b1, 16'h0040, 1'b0); tick();
    drive(1'b1, 16'h0000, 1'b1); tick();
    drive(1'b1, 16'h0000, 1'b1); tick();
    drive(1'b0, 16'h0000, 1'b0);
    chk_bit("frm_any0",  out_any,  1'b0);
    chk_bit("frm_last0", out_last, 1'b0);
    tick();
    chk_bit("frm_any1",  out_any,  1'b1);
    chk_bit("frm_last1", out_last, 1'b0);
`ifdef OR_REDUCE_IDX_EN
    chk_val("frm_idx1", 32'(out_idx), 6);
`endif
    tick();
    chk_bit("frm_any2",  out_any,  1'b1);
    chk_bit("frm_last2", out_last, 1'b1);
    tick();
    chk_bit("frm_next_any",   out_any,   1'b0);
    chk_bit("frm_next_valid", out_valid, 1'b1);
    tick();

    // Stall: out_ready low for 6 cycles while 5 words are offered
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      if (nacc < 5) drive(1'b1, w[nacc], w_last[nacc]);
      else          drive(1'b0, 16'h0000, 1'b0);
      #1;
      if (i >= 4) begin
        chk_bit("stall_valid", out_valid, 1'b1);
        chk_bit("stall_any",   out_any,   1'b1);
        chk_bit("stall_last",  out_last,  1'b0);
      end
      took = in_valid && in_ready;
      tick();
      if (took) nacc++;
    end
    chk_val("stall_accepted", 32'(nacc), 4);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (nacc < 5) drive(1'b1, w[nacc], w_last[nacc]);
      else          drive(1'b0, 16'h0000, 1'b0);
      #1;
      chk_bit("drain_valid", out_valid, 1'b1);
      chk_bit("drain_any",   out_any,   e_any[j]);
      chk_bit("drain_last",  out_last,  e_last[j]);
      took = in_valid && in_ready;
      tick();
      if (took) nacc++;
    end
    drive(1'b0, 16'h0000, 1'b0);
    chk_val("drain_total", 32'(nacc), 5);
    chk_bit("drain_empty", out_valid, 1'b0);

    // Reset mid-frame discards the partial accumulation
    drive(1'b1, 16'h0100, 1'b0); tick();
    drive(1'b1, 16'h0200, 1'b0); tick();
    drive(1'b0, 16'h0000, 1'b0);
    tick(); tick();
    chk_bit("mid_any0", out_any, 1'b1);
    tick();
    chk_bit("mid_any1", out_any, 1'b1);
    out_ready = 1'b0;
    tick();
    chk_bit("mid_held", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_valid", out_valid, 1'b0);
    chk_bit("mid_rst_any",   out_any,   1'b0);
    chk_bit("mid_rst_last",  out_last,  1'b0);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk_bit("mid_rel_in_ready", in_ready, 1'b1);
    drive(1'b1, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    tick(); tick(); tick();
    chk_bit("mid_new_valid", out_valid, 1'b1);
    chk_bit("mid_new_any",   out_any,   1'b0);
    chk_bit("mid_new_last",  out_last,  1'b1);
    tick();

    // Lowest set-bit index words
    drive(1'b1, 16'h0A00, 1'b1); tick();
    drive(1'b1, 16'h0000, 1'b1); tick();
    drive(1'b0, 16'h0000, 1'b0);
    tick(); tick();
    chk_bit("idx_any0", out_any, 1'b1);
`ifdef OR_REDUCE_IDX_EN
    chk_val("idx_val0", 32'(out_idx), 9);
`endif
    tick();
    chk_bit("idx_any1", out_any, 1'b0);
`ifdef OR_REDUCE_IDX_EN
    chk_val("idx_val1", 32'(out_idx), 0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
